// File: rtl/ohs_pkg.sv
// ============================================================================
//  ohs_pkg : fixed-point helpers shared by the boost converter model
//  Rev 1.0
// ============================================================================
`default_nettype none

package ohs_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int DATA_DECIMAL = 22;
  localparam int WIDE         = 128;

  typedef logic signed [WIDE-1:0] wide_t;

  // Clamp a wide signed value into the range of a w-bit signed word.
  function automatic wide_t saturate(input wide_t x, input int w);
    wide_t max_v;
    wide_t min_v;
    max_v = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    min_v = -(wide_t'(1) <<< (w - 1));
    if (x > max_v) begin
      return max_v;
    end else if (x < min_v) begin
      return min_v;
    end
    return x;
  endfunction

  // Rescale a full-width product back to the fixed-point grid, then saturate.
  function automatic wide_t mult_shift(input wide_t prod, input int w, input int d);
    return saturate(prod >>> d, w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_generator.sv
// ============================================================================
//  pwm_generator : free-running counter PWM source, pwm = (counter < comparator)
//  Rev 1.0
// ============================================================================
`default_nettype none

module pwm_generator #(
  parameter int counter_width = 32
) (
  input  logic                     aclk,
  input  logic                     resetn,
  input  logic [counter_width-1:0] period,
  input  logic [counter_width-1:0] comparator,
  output logic [counter_width-1:0] counter,
  output logic                     pwm
);

  logic [counter_width:0]   count_inc;
  logic [counter_width-1:0] next_count;

  // One extra bit keeps the wrap test correct for period = 0 and for max counts.
  always_comb begin
    count_inc  = {1'b0, counter} + (counter_width + 1)'(1);
    next_count = (count_inc >= {1'b0, period}) ? '0 : count_inc[counter_width-1:0];
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      counter <= '0;
      pwm     <= 1'b0;
    end else begin
      counter <= next_count;
      pwm     <= (next_count < comparator);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ohs_boost_l1_model.sv
// ============================================================================
//  ohs_boost_l1_model : forward-Euler fixed-point model of an ideal boost
//  converter, one integration step per ce strobe.
//  Rev 1.0
// ============================================================================
`default_nettype none

module ohs_boost_l1_model
  import ohs_pkg::*;
#(
  parameter int data_width   = DATA_WIDTH,
  parameter int data_decimal = DATA_DECIMAL
) (
  input  logic                         aclk,
  input  logic                         resetn,
  input  logic                         ce,
  input  logic signed [data_width-1:0] kL,
  input  logic signed [data_width-1:0] kC,
  input  logic signed [data_width-1:0] kR,
  input  logic signed [data_width-1:0] vdc,
  input  logic                         S1_pwm,
  output logic signed [data_width-1:0] iL,
  output logic signed [data_width-1:0] vL,
  output logic signed [data_width-1:0] iC,
  output logic signed [data_width-1:0] vC,
  output logic signed [data_width-1:0] iLoad
);

  localparam int W = data_width;

  typedef logic signed [W-1:0]   word_t;
  typedef logic signed [2*W-1:0] prod_t;

  word_t il_reg, vl_reg, ic_reg, vc_reg, iload_reg;

  prod_t p_load, p_l, p_c;
  word_t ild, vld_raw, icd_raw, vld, icd, neg_ild;
  word_t il_next, vc_next;
  wide_t il_sum;

  always_comb begin
    p_load  = prod_t'(vc_reg) * prod_t'(kR);
    ild     = word_t'(mult_shift(wide_t'(p_load), W, data_decimal));
    neg_ild = word_t'(saturate(-wide_t'(ild), W));

    if (S1_pwm) begin
      vld_raw = vdc;
      icd_raw = neg_ild;
    end else begin
      vld_raw = word_t'(saturate(wide_t'(vdc) - wide_t'(vc_reg), W));
      icd_raw = word_t'(saturate(wide_t'(il_reg) - wide_t'(ild), W));
    end

    p_l    = prod_t'(kL) * prod_t'(vld_raw);
    il_sum = saturate(wide_t'(il_reg) + mult_shift(wide_t'(p_l), W, data_decimal), W);

    // Diode blocks reverse current: with S1 open the inductor simply empties
    // and drops out of the circuit for this step.
    vld = vld_raw;
    icd = icd_raw;
    if (il_sum < wide_t'(0)) begin
      il_next = '0;
      if (!S1_pwm) begin
        vld = '0;
        icd = neg_ild;
      end
    end else begin
      il_next = word_t'(il_sum);
    end

    p_c     = prod_t'(kC) * prod_t'(icd);
    vc_next = word_t'(saturate(wide_t'(vc_reg)
                + mult_shift(wide_t'(p_c), W, data_decimal), W));
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      il_reg    <= '0;
      vl_reg    <= '0;
      ic_reg    <= '0;
      vc_reg    <= '0;
      iload_reg <= '0;
    end else if (ce) begin
      il_reg    <= il_next;
      vl_reg    <= vld;
      ic_reg    <= icd;
      vc_reg    <= vc_next;
      iload_reg <= ild;
    end
  end

  assign iL    = il_reg;
  assign vL    = vl_reg;
  assign iC    = ic_reg;
  assign vC    = vc_reg;
  assign iLoad = iload_reg;

endmodule

`default_nettype wire

// File: tb/tb_ohs_boost_l1_model.sv
// ============================================================================
//  tb_ohs_boost_l1_model : randomized and scenario bench against a reference model
//  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ohs_boost_l1_model;

  localparam longint MAXV  = 64'sd2147483647;
  localparam longint MINV  = -64'sd2147483648;
  localparam real    SCALE = 4194304.0;

  logic aclk = 1'b0;
  logic resetn = 1'b0;
  logic ce = 1'b0;
  logic s1_man = 1'b0;
  logic use_pwm = 1'b0;
  logic signed [31:0] kL = 0, kC = 0, kR = 0, vdc = 0;
  logic signed [31:0] iL, vL, iC, vC, iLoad;
  logic [31:0] period = 32'd80, comparator = 32'd0, counter;
  logic pwm, s1_eff;

  int  n_checks = 0;
  int  n_fail = 0;
  bit  checking = 1'b0;
  bit  prev_rstn = 1'b0;

  longint m_il = 0, m_vl = 0, m_ic = 0, m_vc = 0, m_iload = 0;

  assign s1_eff = use_pwm ? pwm : s1_man;

  always #5 aclk = ~aclk;

  ohs_boost_l1_model #(.data_width(32), .data_decimal(22)) dut (
    .aclk(aclk), .resetn(resetn), .ce(ce),
    .kL(kL), .kC(kC), .kR(kR), .vdc(vdc), .S1_pwm(s1_eff),
    .iL(iL), .vL(vL), .iC(iC), .vC(vC), .iLoad(iLoad)
  );

  pwm_generator #(.counter_width(32)) u_pwm (
    .aclk(aclk), .resetn(resetn), .period(period), .comparator(comparator),
    .counter(counter), .pwm(pwm)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input real act, input real exp, input real tol);
    n_checks++;
    if (act < exp - tol * exp || act > exp + tol * exp) begin
      n_fail++;
      $display("FAIL %s: got %f, expected %f within %f relative", name, act, exp, tol);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return sat((a * b) >>> 22);
  endfunction

  // Circuit equations for one Euler step, from the present model state.
  task automatic model_step();
    longint ild, vld, icd, iln, vcn;
    ild = fmul(longint'(kR), m_vc);
    if (s1_eff) begin
      vld = longint'(vdc);
      icd = sat(-ild);
    end else begin
      vld = sat(longint'(vdc) - m_vc);
      icd = sat(m_il - ild);
    end
    iln = sat(m_il + fmul(longint'(kL), vld));
    if (iln < 0) begin
      iln = 0;
      if (!s1_eff) begin
        vld = 0;
        icd = sat(-ild);
      end
    end
    vcn = sat(m_vc + fmul(longint'(kC), icd));
    m_il = iln; m_vl = vld; m_ic = icd; m_vc = vcn; m_iload = ild;
  endtask

  always @(negedge aclk) begin
    if (!resetn) begin
      m_il = 0; m_vl = 0; m_ic = 0; m_vc = 0; m_iload = 0;
    end
    if (checking) begin
      chk("iL", iL, m_il);
      chk("vL", vL, m_vl);
      chk("iC", iC, m_ic);
      chk("vC", vC, m_vc);
      chk("iLoad", iLoad, m_iload);
      chk("iL_sign", {63'd0, iL[31]}, 64'sd0);
      if (resetn && prev_rstn) begin
        chk("pwm_vs_counter", {63'd0, pwm}, {63'd0, (counter < comparator)});
        chk("counter_range", {63'd0, (counter < period || period == 0)}, 64'sd1);
      end
    end
    prev_rstn = resetn;
    if (resetn && ce) model_step();
  end

  function automatic logic signed [31:0] rand_gain();
    int unsigned sel;
    sel = $urandom_range(7);
    if (sel == 0) return $urandom;
    if (sel == 1) return -$signed($urandom_range(1 << 20));
    return $urandom_range(1 << 20);
  endfunction

  function automatic logic signed [31:0] rand_volt();
    return $signed($urandom_range(1 << 30)) - 32'sd536870912;
  endfunction

  task automatic do_step();
    ce = 1'b1;
    @(posedge aclk); #1;
    ce = 1'b0;
  endtask

  task automatic measure(output real v_avg, output real il_avg, output real iload_avg);
    real sv, si, sl;
    sv = 0.0; si = 0.0; sl = 0.0;
    repeat (80) begin
      @(negedge aclk);
      sv += $itor(vC) / SCALE;
      si += $itor(iL) / SCALE;
      sl += $itor(iLoad) / SCALE;
    end
    v_avg = sv / 80.0; il_avg = si / 80.0; iload_avg = sl / 80.0;
  endtask

  initial begin
    real v_avg, il_avg, iload_avg;

    // Reset held with busy inputs and ce active.
    kL = 32'sd41943; kC = 32'sd12710; kR = 32'sd419430; vdc = 32'sd62914560;
    s1_man = 1'b1; ce = 1'b1;
    repeat (2) @(posedge aclk);
    #1 checking = 1'b1;
    @(posedge aclk); #1;
    chk("rst_iL", iL, 0);
    chk("rst_vL", vL, 0);
    chk("rst_vC", vC, 0);

    ce = 1'b0;
    resetn = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    chk("post_rst_iL", iL, 0);
    chk("post_rst_iLoad", iLoad, 0);

    // First step with S1 closed.
    do_step();
    chk("step1_iL", iL, 64'sd629145);
    chk("step1_vL", vL, 64'sd62914560);
    chk("step1_vC", vC, 0);
    chk("step1_iC", iC, 0);
    chk("step1_iLoad", iLoad, 0);

    // Second step with S1 open: inductor feeds the capacitor.
    s1_man = 1'b0;
    do_step();
    chk("step2_iL", iL, 64'sd1258290);
    chk("step2_vL", vL, 64'sd62914560);
    chk("step2_iC", iC, 64'sd629145);
    chk("step2_vC", vC, 64'sd1906);
    chk("step2_iLoad", iLoad, 0);

    repeat (10) @(posedge aclk);
    #1;
    chk("hold_iL", iL, 64'sd1258290);
    chk("hold_vC", vC, 64'sd1906);

    // Asynchronous reset clears outputs before the next clock edge.
    resetn = 1'b0;
    #1;
    chk("async_iL", iL, 0);
    chk("async_vC", vC, 0);
    @(posedge aclk); #1;
    resetn = 1'b1;

    // Randomized phase: gains, voltages, switch, ce and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge aclk); #1;
      ce = ($urandom_range(2) == 0);
      s1_man = $urandom_range(1);
      if (i % 40 == 0) begin
        kL = rand_gain(); kC = rand_gain(); kR = rand_gain(); vdc = rand_volt();
      end
      resetn = ($urandom_range(499) != 0);
    end

    // Closed-loop-free PWM runs: 80 steps per switching period, ce every cycle.
    @(posedge aclk); #1;
    resetn = 1'b0;
    kL = 32'sd41943; kC = 32'sd12710; kR = 32'sd419430; vdc = 32'sd62914560;
    period = 32'd80; comparator = 32'd10; use_pwm = 1'b1; ce = 1'b1;
    @(posedge aclk); #1;
    resetn = 1'b1;
    repeat (25000) @(posedge aclk);
    measure(v_avg, il_avg, iload_avg);
    chk_near("d8_vC", v_avg, 15.0 / 0.875, 0.05);
    chk_near("d8_iLoad", iload_avg, v_avg / 10.0, 0.05);

    @(posedge aclk); #1;
    comparator = 32'd40;
    repeat (20000) @(posedge aclk);
    measure(v_avg, il_avg, iload_avg);
    chk_near("d2_vC", v_avg, 30.0, 0.05);
    chk_near("d2_iL", il_avg, 6.0, 0.10);

    @(posedge aclk); #1;
    kR = 32'sd838861;
    repeat (15000) @(posedge aclk);
    measure(v_avg, il_avg, iload_avg);
    chk_near("load_vC", v_avg, 30.0, 0.05);
    chk_near("load_iLoad", iload_avg, 6.0, 0.05);

    // Discontinuous conduction: vC above vdc with S1 held open.
    @(posedge aclk); #1;
    use_pwm = 1'b0; s1_man = 1'b0;
    repeat (1000) @(posedge aclk);
    #1;
    chk("dcm_iL", iL, 0);
    chk("dcm_vL", vL, 0);
    chk("dcm_iC_plus_iLoad", longint'(iC) + longint'(iLoad), 0);

    @(negedge aclk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
